sm_arb: RTL

Round-robin arbiter and sequencer that shares one `sm_dut` sum-every-3 datapath among `NREQ` requesters. A grant holds for one complete 3-sample group so groups from different requesters never interleave inside the accumulator. The block tags each granted group with its requester ID in an in-order queue and steers the returning sums back to the owner. It sits directly in front of `u_dut`, with `dut_*` ports wired to its `i_dval`/`i`/`o_dval`/`o`.

---
 rtl/sm_arb_pkg.sv | 30 +++
 rtl/sm_arb_idq.sv | 42 ++++
 rtl/sm_arb.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sm_arb_pkg.sv
// Shared types and the round-robin pick helper for the sm_arb requester arbiter.
package sm_arb_pkg;

   // IDs are sized for the largest supported requester count so the package stays parameter-free.
   localparam int unsigned MAX_NREQ = 8;
   localparam int unsigned ID_W     = $clog2(MAX_NREQ);

   typedef enum logic {IDLE, BURST} state_t;

   typedef struct packed {
      logic            found;
      logic [ID_W-1:0] idx;
   } pick_t;

   // First set bit at or after ptr, wrapping; bits above the live requester count are zero.
   function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req, input logic [ID_W-1:0] ptr);
      pick_t           p;
      logic [ID_W-1:0] k;
      p = '0;
      for (int i = MAX_NREQ - 1; i >= 0; i--) begin
         k = ptr + ID_W'(i);
         if (req[k]) begin
            p.found = 1'b1;
            p.idx   = k;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/sm_arb_idq.sv
// In-order requester-ID queue: tags each granted group so its sum can be steered back.
module sm_arb_idq #(
   parameter int unsigned W     = 3,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)  wr_ptr <= wr_ptr + PW'(1);
         if (pop  && !empty) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
   end

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sm_arb.sv
// Round-robin arbiter that feeds whole 3-sample groups into the shared sum datapath
// and steers each returning sum to the requester that owns it.
module sm_arb
   import sm_arb_pkg::*;
#(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned DW     = 8,
   parameter int unsigned GROUP  = 3,
   parameter int unsigned QDEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_dval,
   input  logic [NREQ*DW-1:0]   req_dat,
   output logic [NREQ-1:0]      req_rdy,
   output logic                 dut_i_dval,
   output logic [DW-1:0]        dut_i,
   input  logic                 dut_o_dval,
   input  logic [DW+1:0]        dut_o,
   output logic [NREQ-1:0]      rsp_dval,
   output logic [DW+1:0]        rsp_dat,
   output logic                 busy,
   output logic                 err
);

   localparam int unsigned BW = (GROUP > 1) ? $clog2(GROUP) : 1;

   state_t            state;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   gnt;
   logic [BW-1:0]     beat;

   logic [MAX_NREQ-1:0] req_ext;
   logic [DW-1:0]       dat_arr [MAX_NREQ];
   pick_t               pick;
   logic                accept;
   logic                push;
   logic                pop;
   logic                q_full;
   logic                q_empty;
   logic [ID_W-1:0]     q_dout;

   // Widen the request lanes so the 3-bit grant index always selects in range.
   always_comb begin
      req_ext = MAX_NREQ'(req_dval);
      for (int k = 0; k < MAX_NREQ; k++) dat_arr[k] = '0;
      for (int k = 0; k < NREQ; k++)     dat_arr[k] = req_dat[k*DW +: DW];
   end

   assign pick   = rr_pick(req_ext, rr_ptr);
   assign accept = (state == BURST) && req_ext[gnt];
   assign push   = (state == IDLE) && pick.found && !q_full;
   assign pop    = dut_o_dval && !q_empty;
   assign busy   = (state != IDLE) || !q_empty;

   sm_arb_idq #(
      .W     (ID_W),
      .DEPTH (QDEPTH)
   ) u_idq (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (pick.idx),
      .dout  (q_dout),
      .full  (q_full),
      .empty (q_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         gnt        <= '0;
         beat       <= '0;
         req_rdy    <= '0;
         dut_i_dval <= 1'b0;
         dut_i      <= '0;
         rsp_dval   <= '0;
         rsp_dat    <= '0;
         err        <= 1'b0;
      end else begin
         dut_i_dval <= accept;
         if (accept) dut_i <= dat_arr[gnt];

         // Sums come back in grant order; a sum with no owner is flagged, never delivered.
         rsp_dval <= '0;
         if (pop) begin
            rsp_dval <= NREQ'(1) << q_dout;
            rsp_dat  <= dut_o;
         end else if (dut_o_dval) begin
            err <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (push) begin
                  state   <= BURST;
                  gnt     <= pick.idx;
                  beat    <= '0;
                  req_rdy <= NREQ'(1) << pick.idx;
               end
            end
            BURST: begin
               if (accept) begin
                  if (beat == BW'(GROUP - 1)) begin
                     state   <= IDLE;
                     req_rdy <= '0;
                     rr_ptr  <= (gnt == ID_W'(NREQ - 1)) ? '0 : gnt + ID_W'(1);
                  end else begin
                     beat <= beat + BW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
